// File: rtl/filter_engine_scheduler.sv
// filter_engine_scheduler
//   Time-shares one compensation-filter engine (the FIR stage after CIC
//   decimation) between NUM_CH input channels. Each channel has a one-deep
//   pending buffer. The buffers are granted to the engine in round-robin order
//   over a start/done handshake. Each result is routed back to its own channel
//   output. Overruns and engine timeouts are reported through sticky flags.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   i_ch_valid      per-channel 1-cycle sample strobe
//   i_ch_data       packed input samples, ch k = [k*DATA_W +: DATA_W]
//   o_ch_data       packed filtered results, held until overwritten
//   o_ch_done       1-cycle pulse, o_ch_data slice k updated
//   o_eng_start     1-cycle start pulse to engine
//   o_eng_chan      channel being served, stable from start until done/abort
//   o_eng_data      sample to engine, stable from start until done/abort
//   i_eng_done      engine result valid (1 cycle)
//   i_eng_data      engine result
//   i_stat_clr      clears sticky flags (a same-cycle set wins)
//   o_overrun       sticky per channel: sample overwritten before service
//   o_timeout       sticky: engine did not answer within TIMEOUT cycles
//   o_busy          FSM not in IDLE
//
// State | meaning
// IDLE  | no job in flight; grants the next pending channel (round robin)
// ISSUE | start pulse to the engine; the timeout timer is cleared
// WAIT  | waiting for eng_done; aborts after TIMEOUT cycles
module filter_engine_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 24,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          i_ch_valid,
    input  logic [NUM_CH*DATA_W-1:0]   i_ch_data,
    output logic [NUM_CH*DATA_W-1:0]   o_ch_data,
    output logic [NUM_CH-1:0]          o_ch_done,
    output logic                       o_eng_start,
    output logic [$clog2(NUM_CH)-1:0]  o_eng_chan,
    output logic [DATA_W-1:0]          o_eng_data,
    input  logic                       i_eng_done,
    input  logic [DATA_W-1:0]          i_eng_data,
    input  logic                       i_stat_clr,
    output logic [NUM_CH-1:0]          o_overrun,
    output logic                       o_timeout,
    output logic                       o_busy
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam int TM_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                    r_state;
    logic [CH_W-1:0]           r_rr_ptr;
    logic [NUM_CH-1:0]         r_pend;
    logic [DATA_W-1:0]         r_pend_data [NUM_CH];
    logic [TM_W-1:0]           r_timer;
    logic [CH_W-1:0]           r_eng_chan;
    logic [DATA_W-1:0]         r_eng_data;
    logic                      r_eng_start;
    logic [NUM_CH*DATA_W-1:0]  r_ch_data;
    logic [NUM_CH-1:0]         r_ch_done;
    logic [NUM_CH-1:0]         r_overrun;
    logic                      r_timeout;
    logic                      r_busy;

    state_t                    w_state_nxt;
    logic                      w_pick_found;
    logic [CH_W-1:0]           w_pick_chan;
    logic [NUM_CH-1:0]         w_grant;
    logic                      w_done_hit;
    logic                      w_timeout_hit;
    logic [NUM_CH-1:0]         w_ovr_set;
    logic [CH_W-1:0]           w_rr_next;

    // Round-robin search: first pending channel at or after r_rr_ptr.
    always_comb begin
        int idx;
        idx          = 0;
        w_pick_found = 1'b0;
        w_pick_chan  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(r_rr_ptr) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!w_pick_found && r_pend[CH_W'(idx)]) begin
                w_pick_found = 1'b1;
                w_pick_chan  = CH_W'(idx);
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant       = '0;
        w_done_hit    = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_found) begin
                    w_grant     = NUM_CH'(1) << w_pick_chan;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A result in the last allowed cycle still counts as a completion.
                if (i_eng_done) begin
                    w_done_hit  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_timer == TM_W'(TIMEOUT - 1)) begin
                    w_timeout_hit = 1'b1;
                    w_state_nxt   = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A sample arriving while its channel is being granted is a fresh sample, not an overrun.
    assign w_ovr_set = i_ch_valid & r_pend & ~w_grant;
    assign w_rr_next = (r_eng_chan == CH_W'(NUM_CH - 1)) ? '0 : r_eng_chan + CH_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_pend      <= '0;
            r_timer     <= '0;
            r_eng_chan  <= '0;
            r_eng_data  <= '0;
            r_eng_start <= 1'b0;
            r_ch_data   <= '0;
            r_ch_done   <= '0;
            r_overrun   <= '0;
            r_timeout   <= 1'b0;
            r_busy      <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_pend_data[k] <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_eng_start <= (w_state_nxt == S_ISSUE);

            if (r_state == S_IDLE && w_pick_found) begin
                r_eng_chan <= w_pick_chan;
                r_eng_data <= r_pend_data[w_pick_chan];
            end

            if (r_state == S_ISSUE) begin
                r_timer <= '0;
            end else if (r_state == S_WAIT && !i_eng_done) begin
                r_timer <= r_timer + TM_W'(1);
            end

            if (w_done_hit || w_timeout_hit) begin
                r_rr_ptr <= w_rr_next;
            end

            if (w_done_hit) begin
                r_ch_done <= NUM_CH'(1) << r_eng_chan;
                r_ch_data[r_eng_chan*DATA_W +: DATA_W] <= i_eng_data;
            end else begin
                r_ch_done <= '0;
            end

            for (int k = 0; k < NUM_CH; k++) begin
                if (i_ch_valid[k]) begin
                    r_pend[k]      <= 1'b1;
                    r_pend_data[k] <= i_ch_data[k*DATA_W +: DATA_W];
                end else if (w_grant[k]) begin
                    r_pend[k] <= 1'b0;
                end
            end

            r_overrun <= (r_overrun & ~{NUM_CH{i_stat_clr}}) | w_ovr_set;
            r_timeout <= (r_timeout & ~i_stat_clr) | w_timeout_hit;
        end
    end

    assign o_ch_data   = r_ch_data;
    assign o_ch_done   = r_ch_done;
    assign o_eng_start = r_eng_start;
    assign o_eng_chan  = r_eng_chan;
    assign o_eng_data  = r_eng_data;
    assign o_overrun   = r_overrun;
    assign o_timeout   = r_timeout;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_filter_engine_scheduler.sv
// Testbench for filter_engine_scheduler (NUM_CH=4, DATA_W=24, TIMEOUT=16).
// The engine model answers data+1 five cycles after a start unless it is silenced.
// Expected starts and completions are queued when stimulus is driven.
// A monitor pops and compares them as the DUT produces them.
module tb_filter_engine_scheduler;

    localparam int NUM_CH  = 4;
    localparam int DATA_W  = 24;
    localparam int TIMEOUT = 16;

    typedef struct {
        int              chan;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic                      clk;
    logic                      reset;
    logic [NUM_CH-1:0]         ch_valid;
    logic [NUM_CH*DATA_W-1:0]  ch_data_in;
    logic [NUM_CH*DATA_W-1:0]  ch_data_out;
    logic [NUM_CH-1:0]         ch_done;
    logic                      eng_start;
    logic [1:0]                eng_chan;
    logic [DATA_W-1:0]         eng_data_out;
    logic                      eng_done;
    logic [DATA_W-1:0]         eng_data_in;
    logic                      stat_clr;
    logic [NUM_CH-1:0]         overrun;
    logic                      timeout;
    logic                      busy;

    logic                      model_done;
    logic                      man_done;
    logic                      silent;
    int                        model_cnt;

    int checks = 0;
    int errors = 0;

    exp_t q_start[$];
    exp_t q_done[$];

    assign eng_done = model_done | man_done;

    filter_engine_scheduler #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_ch_valid (ch_valid),
        .i_ch_data  (ch_data_in),
        .o_ch_data  (ch_data_out),
        .o_ch_done  (ch_done),
        .o_eng_start(eng_start),
        .o_eng_chan (eng_chan),
        .o_eng_data (eng_data_out),
        .i_eng_done (eng_done),
        .i_eng_data (eng_data_in),
        .i_stat_clr (stat_clr),
        .o_overrun  (overrun),
        .o_timeout  (timeout),
        .o_busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Engine model: done pulse with data+1 in the 5th cycle after the start cycle.
    initial begin
        model_done  = 1'b0;
        eng_data_in = '0;
        model_cnt   = 0;
        forever begin
            @(posedge clk);
            #1;
            model_done = 1'b0;
            if (model_cnt > 0) begin
                model_cnt--;
                if (model_cnt == 0) model_done = 1'b1;
            end
            if (eng_start && !silent) begin
                model_cnt   = 5;
                eng_data_in = eng_data_out + 1'b1;
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        exp_t e;
        int   dchan;
        forever begin
            @(posedge clk);
            #1;
            if (eng_start) begin
                checks++;
                if (q_start.size() == 0) begin
                    errors++;
                    $display("FAIL start_unexpected: chan=%0d data=%h, required no start", eng_chan, eng_data_out);
                end else begin
                    e = q_start.pop_front();
                    if (eng_chan !== 2'(e.chan) || eng_data_out !== e.data) begin
                        errors++;
                        $display("FAIL start_job: chan=%0d data=%h, required chan=%0d data=%h",
                                 eng_chan, eng_data_out, e.chan, e.data);
                    end
                end
            end
            if (ch_done !== '0) begin
                checks++;
                if ($countones(ch_done) != 1) begin
                    errors++;
                    $display("FAIL done_onehot: ch_done=%b, required exactly one bit", ch_done);
                end
                dchan = 0;
                for (int k = 0; k < NUM_CH; k++) if (ch_done[k]) dchan = k;
                checks++;
                if (q_done.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: ch_done=%b, required none", ch_done);
                end else begin
                    e = q_done.pop_front();
                    if (dchan != e.chan || ch_data_out[dchan*DATA_W +: DATA_W] !== e.data) begin
                        errors++;
                        $display("FAIL done_result: chan=%0d data=%h, required chan=%0d data=%h",
                                 dchan, ch_data_out[dchan*DATA_W +: DATA_W], e.chan, e.data);
                    end
                end
            end
        end
    end

    task automatic push_job(input int chan, input logic [DATA_W-1:0] d, input bit expect_done);
        exp_t e;
        e.chan = chan;
        e.data = d;
        q_start.push_back(e);
        if (expect_done) begin
            e.data = d + 1'b1;
            q_done.push_back(e);
        end
    endtask

    task automatic drive_valid(input logic [NUM_CH-1:0] v, input logic [DATA_W-1:0] d0,
                               input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
                               input logic [DATA_W-1:0] d3);
        @(negedge clk);
        ch_valid   = v;
        ch_data_in = {d3, d2, d1, d0};
        @(negedge clk);
        ch_valid   = '0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (q_start.size() == 0 && q_done.size() == 0 && !busy && model_cnt == 0 && !model_done) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (eng_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        checks++;
        if (busy !== 1'b0 || eng_start !== 1'b0 || ch_done !== '0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b start=%b done=%b timeout=%b, required all 0", busy, eng_start, ch_done, timeout);
        end
        checks++;
        if (ch_data_out !== '0 || eng_data_out !== '0 || eng_chan !== '0 || overrun !== '0) begin
            errors++;
            $display("FAIL reset_data: ch_data=%h eng_data=%h chan=%0d overrun=%b, required all 0",
                     ch_data_out, eng_data_out, eng_chan, overrun);
        end
    endtask

    task automatic test_single;
        bit ok;
        push_job(2, 24'h123456, 1'b1);
        drive_valid(4'b0100, 0, 0, 24'h123456, 0);
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_drain: pending=%0d/%0d, required 0/0", q_start.size(), q_done.size());
        end
        checks++;
        if (ch_data_out[2*DATA_W +: DATA_W] !== 24'h123457) begin
            errors++;
            $display("FAIL single_result: ch2=%h, required 123457", ch_data_out[2*DATA_W +: DATA_W]);
        end
        checks++;
        if (ch_data_out[0 +: DATA_W] !== '0 || ch_data_out[DATA_W +: DATA_W] !== '0 ||
            ch_data_out[3*DATA_W +: DATA_W] !== '0) begin
            errors++;
            $display("FAIL single_others: ch_data=%h, required other channels 0", ch_data_out);
        end
    endtask

    task automatic test_round_robin;
        bit ok;
        push_job(1, 24'h000111, 1'b1);
        drive_valid(4'b0010, 0, 24'h000111, 0, 0);
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rr_single_drain: pending=%0d/%0d, required 0/0", q_start.size(), q_done.size());
        end
        for (int rep = 0; rep < 2; rep++) begin
            push_job(2, 24'h200002 + rep, 1'b1);
            push_job(3, 24'h300003 + rep, 1'b1);
            push_job(0, 24'h400000 + rep, 1'b1);
            push_job(1, 24'h500001 + rep, 1'b1);
            drive_valid(4'b1111, 24'h400000 + rep, 24'h500001 + rep, 24'h200002 + rep, 24'h300003 + rep);
            wait_drain(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rr_burst_drain: rep=%0d pending=%0d/%0d, required 0/0", rep, q_start.size(), q_done.size());
            end
        end
        checks++;
        if (overrun !== '0) begin
            errors++;
            $display("FAIL rr_overrun: overrun=%b, required 0000", overrun);
        end
    endtask

    task automatic test_overrun;
        bit ok;
        push_job(1, 24'h0000a1, 1'b1);
        push_job(0, 24'd200, 1'b1);
        @(negedge clk);
        ch_valid   = 4'b0010;
        ch_data_in = {24'h0, 24'h0, 24'h0000a1, 24'h0};
        @(negedge clk);
        ch_valid   = '0;
        wait_start(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ovr_start: no start seen, required start for ch1");
        end
        @(negedge clk);
        ch_valid   = 4'b0001;
        ch_data_in = {24'h0, 24'h0, 24'h0, 24'd100};
        @(negedge clk);
        ch_data_in = {24'h0, 24'h0, 24'h0, 24'd200};
        @(negedge clk);
        ch_valid   = '0;
        wait_drain(ok);
        checks++;
        if (!ok || overrun !== 4'b0001) begin
            errors++;
            $display("FAIL ovr_flag: drained=%b overrun=%b, required drained=1 overrun=0001", ok, overrun);
        end
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        checks++;
        if (overrun !== '0) begin
            errors++;
            $display("FAIL ovr_clear: overrun=%b, required 0000", overrun);
        end
    endtask

    task automatic test_timeout;
        bit ok;
        int n;
        silent = 1'b1;
        push_job(1, 24'h0aaaa1, 1'b0);
        push_job(3, 24'h0aaaa3, 1'b1);
        drive_valid(4'b1010, 0, 24'h0aaaa1, 0, 24'h0aaaa3);
        wait_start(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL to_start: no start seen, required start for ch1");
        end
        // ISSUE, then 16 WAIT cycles; the registered flag shows one cycle after the last WAIT cycle.
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (timeout) break;
        end
        checks++;
        if (timeout !== 1'b1 || n != 17) begin
            errors++;
            $display("FAIL to_flag: timeout=%b after %0d cycles, required 1 after 17", timeout, n);
        end
        // FSM is in IDLE this cycle: a late done must be ignored.
        silent   = 1'b0;
        man_done = 1'b1;
        @(posedge clk);
        #1;
        man_done = 1'b0;
        checks++;
        if (ch_done !== '0) begin
            errors++;
            $display("FAIL to_late_done: ch_done=%b, required 0000", ch_done);
        end
        wait_drain(ok);
        checks++;
        if (!ok || timeout !== 1'b1) begin
            errors++;
            $display("FAIL to_next_job: drained=%b timeout=%b, required 1 and 1", ok, timeout);
        end
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_clear: timeout=%b, required 0", timeout);
        end
    endtask

    task automatic test_reset_mid_wait;
        bit ok;
        bit seen;
        push_job(0, 24'h00c0de, 1'b0);
        drive_valid(4'b0001, 24'h00c0de, 0, 0, 0);
        wait_start(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_start: no start seen, required start for ch0");
        end
        @(negedge clk);
        ch_valid   = 4'b0110;
        ch_data_in = {24'h0, 24'h00cc02, 24'h00cc01, 24'h0};
        @(negedge clk);
        ch_valid   = '0;
        reset      = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || eng_start !== 1'b0 || ch_done !== '0 || ch_data_out !== '0 ||
            eng_chan !== '0 || eng_data_out !== '0 || overrun !== '0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL rst_outputs: busy=%b start=%b done=%b chan=%0d eng_data=%h ch_data=%h, required all 0",
                     busy, eng_start, ch_done, eng_chan, eng_data_out, ch_data_out);
        end
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (ch_done !== '0 || eng_start || busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rst_quiet: activity seen after reset, required none");
        end
    endtask

    task automatic test_grant_same_cycle;
        bit ok;
        push_job(3, 24'h0333aa, 1'b1);
        push_job(3, 24'h0333bb, 1'b1);
        @(negedge clk);
        ch_valid   = 4'b1000;
        ch_data_in = {24'h0333aa, 24'h0, 24'h0, 24'h0};
        // ch3 is granted on the next edge, while the second sample arrives.
        @(negedge clk);
        ch_data_in = {24'h0333bb, 24'h0, 24'h0, 24'h0};
        @(negedge clk);
        ch_valid   = '0;
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL same_drain: pending=%0d/%0d, required 0/0", q_start.size(), q_done.size());
        end
        checks++;
        if (overrun !== '0 || ch_data_out[3*DATA_W +: DATA_W] !== 24'h0333bc) begin
            errors++;
            $display("FAIL same_result: overrun=%b ch3=%h, required 0000 and 0333bc",
                     overrun, ch_data_out[3*DATA_W +: DATA_W]);
        end
    endtask

    initial begin
        reset      = 1'b1;
        ch_valid   = '0;
        ch_data_in = '0;
        stat_clr   = 1'b0;
        man_done   = 1'b0;
        silent     = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_overrun();
        test_timeout();
        test_reset_mid_wait();
        test_grant_same_cycle();
        checks++;
        if (q_start.size() != 0 || q_done.size() != 0) begin
            errors++;
            $display("FAIL leftover: starts=%0d dones=%0d outstanding, required 0", q_start.size(), q_done.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
